// File: rtl/vga_text_pkg.sv
// Shared constants, FSM encoding and write-payload type for the VRAM text writer.
package vga_text_pkg;

  localparam int unsigned DEF_COLS = 40;
  localparam int unsigned DEF_ROWS = 30;
  localparam int unsigned ROW_W    = 5;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CODE_W   = 8;

  localparam logic [CODE_W-1:0] CH_SPACE = 8'h20;
  localparam logic [CODE_W-1:0] CH_BS    = 8'h08;
  localparam logic [CODE_W-1:0] CH_LF    = 8'h0A;
  localparam logic [CODE_W-1:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLRROW = 2'd1,
    ST_CLRALL = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CUR_NOP  = 3'd0,
    CUR_INC  = 3'd1,
    CUR_DEC  = 3'd2,
    CUR_NL   = 3'd3,
    CUR_CR   = 3'd4,
    CUR_HOME = 3'd5
  } cur_cmd_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CODE_W-1:0] code;
  } vram_wr_t;

  // Cell address as the display side reads it: {row[5:0], col[5:0]}.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/vram_text_writer_if.sv
// CPU-side character stream and VRAM write port of the text writer.
interface vram_text_writer_if;
  import vga_text_pkg::*;

  logic [CODE_W-1:0] char_in;
  logic              char_valid;
  logic              char_ready;
  logic              clr_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic [ROW_W-1:0]  cursor_row;
  logic [COL_W-1:0]  cursor_col;
  logic              busy;

  modport master (
    output char_in, char_valid, clr_req,
    input  char_ready, vram_we, vram_addr, vram_data, cursor_row, cursor_col, busy
  );

  modport slave (
    input  char_in, char_valid, clr_req,
    output char_ready, vram_we, vram_addr, vram_data, cursor_row, cursor_col, busy
  );

endinterface

// File: rtl/text_cursor.sv
// Row/column cursor with inc, dec, newline, carriage-return and home commands.
module text_cursor
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic             clk,
  input  logic             reset,
  input  cur_cmd_e         cmd,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] prev_row_c,
  output logic [COL_W-1:0] prev_col_c,
  output logic             eol_c,
  output logic             home_c
);

  logic [ROW_W-1:0] row_q, row_d, next_row_c;
  logic [COL_W-1:0] col_q, col_d;

  assign eol_c      = (col_q == COL_W'(COLS - 1));
  assign home_c     = (row_q == '0) && (col_q == '0);
  assign next_row_c = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

  // Cell one step back, wrapping to the end of the previous row.
  always_comb begin
    prev_row_c = row_q;
    prev_col_c = col_q - COL_W'(1);
    if (col_q == '0) begin
      prev_row_c = row_q - ROW_W'(1);
      prev_col_c = COL_W'(COLS - 1);
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (cmd)
      CUR_INC: begin
        if (eol_c) begin
          col_d = '0;
          row_d = next_row_c;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      CUR_DEC: begin
        if (!home_c) begin
          row_d = prev_row_c;
          col_d = prev_col_c;
        end
      end
      CUR_NL: begin
        col_d = '0;
        row_d = next_row_c;
      end
      CUR_CR:   col_d = '0;
      CUR_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/vram_text_writer.sv
// Character-stream to VRAM writer: cursor handling, row clear on advance, full-screen clear.
module vram_text_writer
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input logic               clk,
  input logic               reset,
  vram_text_writer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_CLRROW = 2'(ST_CLRROW);
  localparam logic [1:0] S_CLRALL = 2'(ST_CLRALL);

  logic [1:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             we_q, we_d;
  vram_wr_t         wr_q, wr_d;
  logic [ROW_W-1:0] sweep_row_q, sweep_row_d;
  logic [COL_W-1:0] sweep_col_q, sweep_col_d;

  cur_cmd_e         cur_cmd;
  logic [ROW_W-1:0] cur_row, prev_row;
  logic [COL_W-1:0] cur_col, prev_col;
  logic             cur_eol, cur_home;
  logic             accept, last_col, last_row, pend_now;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cur_cmd),
    .row        (cur_row),
    .col        (cur_col),
    .prev_row_c (prev_row),
    .prev_col_c (prev_col),
    .eol_c      (cur_eol),
    .home_c     (cur_home)
  );

  // A clear request in the same cycle steals the slot from the character.
  assign accept   = bus.char_valid && ready_q && !bus.clr_req;
  assign last_col = (sweep_col_q == COL_W'(COLS - 1));
  assign last_row = (sweep_row_q == ROW_W'(ROWS - 1));
  assign pend_now = pend_q || bus.clr_req;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    sweep_row_d = sweep_row_q;
    sweep_col_d = sweep_col_q;
    we_d        = 1'b0;
    wr_d        = wr_q;
    cur_cmd     = CUR_NOP;

    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d     = S_CLRALL;
          sweep_row_d = '0;
          sweep_col_d = '0;
        end else if (accept) begin
          case (bus.char_in)
            CH_CR: cur_cmd = CUR_CR;
            CH_LF: begin
              cur_cmd     = CUR_NL;
              state_d     = S_CLRROW;
              sweep_col_d = '0;
            end
            CH_BS: begin
              if (!cur_home) begin
                cur_cmd = CUR_DEC;
                we_d    = 1'b1;
                wr_d    = '{addr: cell_addr(prev_row, prev_col), code: CH_SPACE};
              end
            end
            default: begin
              cur_cmd = CUR_INC;
              we_d    = 1'b1;
              wr_d    = '{addr: cell_addr(cur_row, cur_col), code: bus.char_in};
              if (cur_eol) begin
                state_d     = S_CLRROW;
                sweep_col_d = '0;
              end
            end
          endcase
        end
      end

      // Blank the row the cursor just moved onto.
      S_CLRROW: begin
        we_d   = 1'b1;
        wr_d   = '{addr: cell_addr(cur_row, sweep_col_q), code: CH_SPACE};
        pend_d = pend_now;
        if (last_col) begin
          sweep_col_d = '0;
          sweep_row_d = '0;
          state_d     = pend_now ? S_CLRALL : S_IDLE;
          pend_d      = 1'b0;
        end else begin
          sweep_col_d = sweep_col_q + COL_W'(1);
        end
      end

      S_CLRALL: begin
        we_d   = 1'b1;
        wr_d   = '{addr: cell_addr(sweep_row_q, sweep_col_q), code: CH_SPACE};
        pend_d = pend_now;
        if (last_col) begin
          sweep_col_d = '0;
          if (last_row) begin
            sweep_row_d = '0;
            cur_cmd     = CUR_HOME;
            state_d     = pend_now ? S_CLRALL : S_IDLE;
            pend_d      = 1'b0;
          end else begin
            sweep_row_d = sweep_row_q + ROW_W'(1);
          end
        end else begin
          sweep_col_d = sweep_col_q + COL_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) && !pend_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      wr_q        <= '0;
      sweep_row_q <= '0;
      sweep_col_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      wr_q        <= wr_d;
      sweep_row_q <= sweep_row_d;
      sweep_col_q <= sweep_col_d;
    end
  end

  assign bus.char_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_addr  = wr_q.addr;
  assign bus.vram_data  = {{(DATA_W - CODE_W){1'b0}}, wr_q.code};
  assign bus.cursor_row = cur_row;
  assign bus.cursor_col = cur_col;

endmodule
